pkt_out_arbiter: RTL and testbench
==================================

Name: pkt_out_arbiter

Overview:
- Merges the 16-bit output streams of N_CH parallel application units (sha256crypt pkt_comm instances) into the single output_fifo write port.
- Packets stay atomic: once a channel is granted, only its words are forwarded until it presents its last word.
- Channels are served round-robin; aggregate idle and sticky error status feed the vcr/error_r path.
- Sits in the PKT_COMM_CLK domain, between the application instances and output_fifo.

Parameters:
- N_CH, 4, number of application channels (1..16).
- WIDTH, 16, data word width.
- TIMEOUT, 1024, maximum consecutive empty cycles allowed mid-packet on the granted channel.
- MAX_PKT_WORDS, 4096, maximum words per packet including the last word.

Ports:
- CLK  in  1  PKT_COMM_CLK; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ch_dout  in  N_CH*WIDTH  per-channel first-word-fall-through data; channel k occupies bits [k*WIDTH +: WIDTH].
- ch_last  in  N_CH  current ch_dout word is the final word of its packet.
- ch_empty  in  N_CH  channel has no word available.
- ch_rd_en  out  N_CH  pop current word from the channel; one-hot or zero.
- ch_idle  in  N_CH  channel's cores are idle.
- dout  out  WIDTH  word to output_fifo.
- wr_en  out  1  write strobe to output_fifo.
- full  in  1  output_fifo full.
- cores_idle  out  1  all channels idle and no packet in flight.
- arb_status  out  8  bit0 timeout error (sticky), bit1 overlength error (sticky), bits[7:4] current/last granted channel, bits[3:2] zero.
- pkt_count  out  16  packets completed since reset; wraps 0xFFFF->0.

Behaviour:
- Reset values: ch_rd_en=0, wr_en=0, dout=0, arb_status=0, pkt_count=0, state=ARB, ptr=N_CH-1, word_cnt=0, wd_cnt=0.
  - RST mid-packet abandons the packet; no further words are forwarded.
- Datapath is combinational from the selected channel, zero latency:
  - dout = ch_dout[grant].
  - wr_en = ch_rd_en[grant].
  - ch_rd_en[grant] = (state==XFER) & ~ch_empty[grant] & ~full & ~err.
  - dout is 0 whenever state != XFER.
- err = arb_status[0] | arb_status[1]. On err, all transfers stop until RST.
- State ARB (one cycle per decision):
  - Search channels ptr+1, ptr+2, ... modulo N_CH; select the first with ~ch_empty.
  - If one is found and ~err: grant<=k, word_cnt<=0, wd_cnt<=0, go XFER.
  - If none is found: stay in ARB.
  - No word is transferred in an ARB cycle.
- State XFER:
  - On a transfer cycle (ch_rd_en[grant]=1):
    - word_cnt<=word_cnt+1, wd_cnt<=0.
    - If ch_last[grant]: ptr<=grant, pkt_count<=pkt_count+1, go ARB.
    - If not last and word_cnt+1 == MAX_PKT_WORDS: set arb_status[1]. The offending word is still written.
  - Cycle with ch_empty[grant]=1 and ~full: wd_cnt<=wd_cnt+1. When wd_cnt reaches TIMEOUT-1, set arb_status[0].
  - Cycle with full=1: wd_cnt holds; backpressure is never a timeout.
  - Other channels' empty/last inputs are ignored while in XFER.
- Fairness: a channel that just completed a packet has the lowest priority in the next ARB.
  - Back-to-back packets from one channel, with others empty, cost one ARB cycle between packets.
- Single-word packet (ch_last on the first word): one XFER cycle, then ARB.
- ch_last is sampled only on transfer cycles.
- Counter widths:
  - word_cnt: clog2(MAX_PKT_WORDS+1) bits.
  - wd_cnt: clog2(TIMEOUT) bits.
  - Both saturate and do not wrap.
- cores_idle = (&ch_idle) & (&ch_empty) & (state==ARB); registered, reset 0.
- N_CH=1: the arbiter degenerates to a pass-through with packet checks; grant is always 0.

Test Plan:
- N_CH=4; ch1 and ch3 each hold one 3-word packet (0x1111,0x1112,0x1113 last / 0x3331,0x3332,0x3333 last), full=0 -> output order 1111,1112,1113 then 3331,3332,3333; one idle cycle between packets; pkt_count=2; arb_status[7:4]=3.
- All four channels hold continuous 2-word packets -> grant sequence 0,1,2,3,0,...; no channel gets two consecutive packets; every packet is contiguous on dout.
- ch2 mid-packet with full held 1 for 2000 cycles, then released -> no timeout; remaining words are written in order after release; arb_status=0x20.
- ch0 sends one non-last word, then stays empty, TIMEOUT=1024 -> arb_status[0] set exactly 1024 cycles after the transfer; wr_en stays 0 afterwards even when ch0 and other channels have data; cleared only by RST.
- MAX_PKT_WORDS=8; ch1 sends 9 words with no last -> 8 words written, arb_status[1] set in the cycle after the 8th write, 9th word never popped.
- RST asserted for one cycle mid-packet on ch2 -> next cycle: all outputs at reset values, pkt_count=0; a new packet on ch2 is then granted from ARB, starting the search at ch0.

Source files
------------

// File: rtl/pkt_out_arbiter.sv
// Round-robin, packet-atomic merge of N_CH first-word-fall-through channels onto the output_fifo port.
// Zero-latency datapath; sticky timeout/overlength errors halt forwarding until reset.
module pkt_out_arbiter #(
    parameter int N_CH          = 4,
    parameter int WIDTH         = 16,
    parameter int TIMEOUT       = 1024,
    parameter int MAX_PKT_WORDS = 4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_CH*WIDTH-1:0] ch_dout,
    input  logic [N_CH-1:0]       ch_last,
    input  logic [N_CH-1:0]       ch_empty,
    output logic [N_CH-1:0]       ch_rd_en,
    input  logic [N_CH-1:0]       ch_idle,
    output logic [WIDTH-1:0]      dout,
    output logic                  wr_en,
    input  logic                  full,
    output logic                  cores_idle,
    output logic [7:0]            arb_status,
    output logic [15:0]           pkt_count
);

    localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int WCW = $clog2(MAX_PKT_WORDS + 1);
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [WCW-1:0] WC_MAX  = WCW'(MAX_PKT_WORDS);
    localparam logic [WCW-1:0] WC_LAST = WCW'(MAX_PKT_WORDS - 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic {ARB, XFER} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    ptr, grant, pick, cand;
    logic             found;
    logic [WCW-1:0]   word_cnt;
    logic [WDW-1:0]   wd_cnt;
    logic             to_err, ol_err, err, xfer;
    logic [WIDTH-1:0] ch_word [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_word
        assign ch_word[k] = ch_dout[k*WIDTH +: WIDTH];
    end

    assign err        = to_err | ol_err;
    assign arb_status = {4'(grant), 2'b00, ol_err, to_err};
    assign xfer       = (state == XFER) & ~ch_empty[grant] & ~full & ~err & ~RST;

    // Search starts just after the last completed channel, so it gets lowest priority.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = CW'((int'(ptr) + i) % N_CH);
            if (!found && !ch_empty[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RST) state <= ARB;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ARB:  if (found && !err)         state_nx = XFER;
            XFER: if (xfer && ch_last[grant]) state_nx = ARB;
            default:                          state_nx = ARB;
        endcase
    end

    always_comb begin
        ch_rd_en        = '0;
        ch_rd_en[grant] = xfer;
        wr_en           = xfer;
        dout            = (state == XFER && !RST) ? ch_word[grant] : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr        <= CW'(N_CH - 1);
            grant      <= '0;
            word_cnt   <= '0;
            wd_cnt     <= '0;
            to_err     <= 1'b0;
            ol_err     <= 1'b0;
            pkt_count  <= '0;
            cores_idle <= 1'b0;
        end else begin
            cores_idle <= (&ch_idle) & (&ch_empty) & (state == ARB);
            if (state == ARB) begin
                if (found && !err) begin
                    grant    <= pick;
                    word_cnt <= '0;
                    wd_cnt   <= '0;
                end
            end else if (xfer) begin
                if (word_cnt != WC_MAX) word_cnt <= word_cnt + 1'b1;
                wd_cnt <= '0;
                if (ch_last[grant]) begin
                    ptr       <= grant;
                    pkt_count <= pkt_count + 16'd1;
                end else if (word_cnt == WC_LAST) begin
                    ol_err <= 1'b1;
                end
            end else if (ch_empty[grant] && !full && !err) begin
                // Only starvation by the granted channel counts; backpressure never does.
                if (wd_cnt == WD_LAST) to_err <= 1'b1;
                else                   wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_out_arbiter.sv
// Scoreboard bench for pkt_out_arbiter: channel FWFT models feed the DUT, expected words are
// queued at stimulus time and a negedge monitor compares every write.
module tb_pkt_out_arbiter;

    localparam int N_CH    = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 1024;
    localparam int MAXW    = 8;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic [N_CH*WIDTH-1:0] ch_dout;
    logic [N_CH-1:0]       ch_last, ch_empty, ch_rd_en, ch_idle;
    logic [WIDTH-1:0]      dout;
    logic                  wr_en, full, cores_idle;
    logic [7:0]            arb_status;
    logic [15:0]           pkt_count;

    int n_checks = 0;
    int n_errors = 0;
    int nwr = 0;
    int cycle_cnt = 0;
    int wr_cycles[$];
    logic [16:0] chq [N_CH][$];
    logic [15:0] expq[$];
    logic [N_CH-1:0] pend = '0;

    pkt_out_arbiter #(.N_CH(N_CH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .MAX_PKT_WORDS(MAXW)) dut (
        .CLK(CLK), .RST(RST), .ch_dout(ch_dout), .ch_last(ch_last), .ch_empty(ch_empty),
        .ch_rd_en(ch_rd_en), .ch_idle(ch_idle), .dout(dout), .wr_en(wr_en), .full(full),
        .cores_idle(cores_idle), .arb_status(arb_status), .pkt_count(pkt_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        logic [16:0] e;
        for (int k = 0; k < N_CH; k++) begin
            if (chq[k].size() == 0) begin
                ch_empty[k]               = 1'b1;
                ch_last[k]                = 1'b0;
                ch_dout[k*WIDTH +: WIDTH] = '0;
            end else begin
                e                         = chq[k][0];
                ch_empty[k]               = 1'b0;
                ch_last[k]                = e[16];
                ch_dout[k*WIDTH +: WIDTH] = e[15:0];
            end
        end
    endtask

    // Channel models: pop what the DUT read at the last edge, then present the next word.
    initial begin
        refresh();
        forever begin
            @(posedge CLK);
            #1;
            for (int k = 0; k < N_CH; k++)
                if (pend[k] && chq[k].size() > 0) void'(chq[k].pop_front());
            refresh();
        end
    end

    // Monitor: every written word must be the next expected one.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge CLK);
            cycle_cnt++;
            pend = ch_rd_en;
            check("rd_en_onehot0", 32'($onehot0(ch_rd_en)), 1);
            if (wr_en) begin
                nwr++;
                wr_cycles.push_back(cycle_cnt);
                check("wr_while_full", 32'(full), 0);
                if (expq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: dout 0x%0h written, no word expected", dout);
                end else begin
                    e = expq.pop_front();
                    check("dout", 32'(dout), 32'(e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic push(input int ch, input logic [15:0] d, input logic last, input bit exp_it);
        chq[ch].push_back({last, d});
        if (exp_it) expq.push_back(d);
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int c = 0;
        while (nwr < target && c < budget) begin
            @(negedge CLK);
            #1;
            c++;
        end
        check(name, 32'(nwr >= target), 1);
    endtask

    task automatic flush_and_reset();
        for (int k = 0; k < N_CH; k++) chq[k].delete();
        expq.delete();
        RST = 1'b1;
        step(1);
        RST = 1'b0;
    endtask

    initial begin
        int base, b;
        ch_idle = '1;
        full    = 1'b0;
        step(3);
        RST = 1'b0;

        // Reset state
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_rd_en", 32'(ch_rd_en), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_arb_status", 32'(arb_status), 0);
        check("rst_pkt_count", 32'(pkt_count), 0);
        check("rst_cores_idle", 32'(cores_idle), 0);
        step(1);
        check("cores_idle_set", 32'(cores_idle), 1);
        ch_idle[2] = 1'b0;
        step(2);
        check("cores_idle_busy", 32'(cores_idle), 0);
        ch_idle = '1;

        // Two 3-word packets on ch1 and ch3
        push(1, 16'h1111, 1'b0, 1); push(1, 16'h1112, 1'b0, 1); push(1, 16'h1113, 1'b1, 1);
        push(3, 16'h3331, 1'b0, 1); push(3, 16'h3332, 1'b0, 1); push(3, 16'h3333, 1'b1, 1);
        b    = wr_cycles.size();
        base = nwr;
        wait_writes(base + 6, 60, "t1_drain");
        if (wr_cycles.size() >= b + 6) begin
            check("t1_contiguous", 32'(wr_cycles[b+1] - wr_cycles[b]), 1);
            check("t1_arb_gap", 32'(wr_cycles[b+3] - wr_cycles[b+2]), 2);
        end
        step(1);
        check("t1_pkt_count", 32'(pkt_count), 2);
        check("t1_arb_status", 32'(arb_status), 32'h30);
        step(2);
        check("t1_cores_idle", 32'(cores_idle), 1);

        // Round robin with all channels continuously loaded
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < N_CH; k++) begin
                push(k, {4'hC, 4'(k), 4'(p), 4'h0}, 1'b0, 1);
                push(k, {4'hC, 4'(k), 4'(p), 4'h1}, 1'b1, 1);
            end
        base = nwr;
        wait_writes(base + 24, 200, "t2_drain");
        step(1);
        check("t2_pkt_count", 32'(pkt_count), 14);
        check("t2_arb_status", 32'(arb_status), 32'h30);

        // Long backpressure mid-packet is not a timeout
        push(2, 16'h2221, 1'b0, 1); push(2, 16'h2222, 1'b0, 1);
        push(2, 16'h2223, 1'b0, 1); push(2, 16'h2224, 1'b1, 1);
        base = nwr;
        wait_writes(base + 1, 40, "t3_first");
        step(1);
        full = 1'b1;
        step(2000);
        check("t3_held_writes", 32'(nwr), 32'(base + 1));
        check("t3_status_full", 32'(arb_status), 32'h20);
        full = 1'b0;
        wait_writes(base + 4, 40, "t3_drain");
        step(1);
        check("t3_arb_status", 32'(arb_status), 32'h20);
        check("t3_pkt_count", 32'(pkt_count), 15);

        // Reset mid-packet on ch2 (ptr left at 1 beforehand)
        push(1, 16'h1AAA, 1'b1, 1);
        push(2, 16'h2B01, 1'b0, 1); push(2, 16'h2B02, 1'b0, 1);
        push(2, 16'h2B03, 1'b0, 0); push(2, 16'h2B04, 1'b1, 0);
        base = nwr;
        wait_writes(base + 3, 40, "t6_partial");
        step(1);
        flush_and_reset();
        check("t6_wr_en", 32'(wr_en), 0);
        check("t6_rd_en", 32'(ch_rd_en), 0);
        check("t6_dout", 32'(dout), 0);
        check("t6_arb_status", 32'(arb_status), 0);
        check("t6_pkt_count", 32'(pkt_count), 0);
        push(1, 16'h1C01, 1'b1, 1);
        push(2, 16'h2C01, 1'b0, 1); push(2, 16'h2C02, 1'b1, 1);
        base = nwr;
        wait_writes(base + 3, 40, "t6_drain");
        step(1);
        check("t6_new_pkt_count", 32'(pkt_count), 2);
        check("t6_new_arb_status", 32'(arb_status), 32'h20);

        // Timeout: one non-last word on ch0 then starvation
        push(0, 16'h0E01, 1'b0, 1);
        base = nwr;
        wait_writes(base + 1, 40, "t4_first");
        step(1);
        step(1023);
        check("t4_before_timeout", 32'(arb_status), 32'h00);
        step(1);
        check("t4_timeout", 32'(arb_status), 32'h01);
        push(0, 16'h0E02, 1'b1, 0);
        push(3, 16'h3E01, 1'b1, 0);
        step(20);
        check("t4_rd_en_halted", 32'(ch_rd_en), 0);
        check("t4_ch0_kept", 32'(chq[0].size()), 1);
        check("t4_ch3_kept", 32'(chq[3].size()), 1);
        check("t4_sticky", 32'(arb_status), 32'h01);
        flush_and_reset();
        check("t4_cleared", 32'(arb_status), 0);

        // Overlength: 9 words without last on ch1
        for (int i = 1; i <= 9; i++) push(1, 16'h1900 + 16'(i), 1'b0, i <= MAXW);
        base = nwr;
        wait_writes(base + MAXW, 60, "t5_writes");
        check("t5_before_err", 32'(arb_status), 32'h10);
        step(1);
        check("t5_overlength", 32'(arb_status), 32'h12);
        step(10);
        check("t5_ninth_kept", 32'(chq[1].size()), 1);
        check("t5_rd_en_halted", 32'(ch_rd_en), 0);
        check("t5_pkt_count", 32'(pkt_count), 0);
        flush_and_reset();
        check("t5_cleared", 32'(arb_status), 0);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
